// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM
// states and the byte/halfword lane-select constants used by the
// alignment logic.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // Byte lanes selected by addr[1:0], little-endian.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  // Halfword lanes selected by addr[1].
  localparam logic LANE_H0 = 1'b0;
  localparam logic LANE_H1 = 1'b1;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Ports:
//   size_i     access size
//   sext_i     sign (1) / zero (0) extension for sub-word loads
//   byte_off_i byte offset within the word (addr[1:0])
//   rdata_i    word read from memory
//   wdata_i    right-justified store data
//   load_o     addressed lane shifted to bit 0 and extended
//   merge_o    read word with the addressed lane replaced by store data
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic        sext_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (byte_off_i)
      LANE_B0: byte_v = rdata_i[7:0];
      LANE_B1: byte_v = rdata_i[15:8];
      LANE_B2: byte_v = rdata_i[23:16];
      LANE_B3: byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = (byte_off_i[1] == LANE_H1) ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    load_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{sext_i & byte_v[7]}}, byte_v};
      SZ_HALF: load_o = {{16{sext_i & half_v[15]}}, half_v};
      default: load_o = rdata_i;
    endcase
  end

  always_comb begin
    merge_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        case (byte_off_i)
          LANE_B0: merge_o[7:0]   = wdata_i[7:0];
          LANE_B1: merge_o[15:8]  = wdata_i[7:0];
          LANE_B2: merge_o[23:16] = wdata_i[7:0];
          LANE_B3: merge_o[31:24] = wdata_i[7:0];
          default: merge_o        = rdata_i;
        endcase
      end
      SZ_HALF: begin
        if (byte_off_i[1] == LANE_H0) merge_o[15:0]  = wdata_i[15:0];
        else                          merge_o[31:16] = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one byte/halfword/word access from the pipeline,
// checks alignment and range, then drives a word-addressed data memory.
// Sub-word stores are read-modify-write.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req, we, size, sign_ext request, store/load, size code, load extension
//   addr, store_data        byte address, right-justified store data
//   ready                   unit is idle and will accept req
//   done, err               one-cycle completion pulse, fault flag
//   load_data               extended load result, held until next accept
//   mem_*                   word-addressed memory interface
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_q;
  logic        we_q;
  size_e       size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic        fault_q;
  logic [31:0] ext_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] load_q;
  logic [31:0] maddr_q;
  logic [31:0] mwdata_q;
  logic        mread_q;
  logic        mwrite_q;

  logic        fault_d;
  logic [31:0] align_load;
  logic [31:0] align_merge;

  always_comb begin
    fault_d = 1'b0;
    case (size)
      2'b11:   fault_d = 1'b1;
      2'b01:   fault_d = addr[0];
      2'b10:   fault_d = (addr[1:0] != 2'b00);
      default: fault_d = 1'b0;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(DEPTH)) fault_d = 1'b1;
  end

  // Alignment only matters in READ, where the latched request and the
  // live memory word are both valid on the same edge.
  lsu_align u_align (
    .size_i     (size_q),
    .sext_i     (sext_q),
    .byte_off_i (addr_q[1:0]),
    .rdata_i    (mem_read_data),
    .wdata_i    (sdata_q),
    .load_o     (align_load),
    .merge_o    (align_merge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      sext_q   <= 1'b0;
      addr_q   <= '0;
      sdata_q  <= '0;
      fault_q  <= 1'b0;
      ext_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      load_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mread_q  <= 1'b0;
      mwrite_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size_e'(size);
            sext_q  <= sign_ext;
            addr_q  <= addr;
            sdata_q <= store_data;
            fault_q <= fault_d;
            ext_q   <= '0;
            load_q  <= '0;
            if (fault_d) begin
              state_q <= ST_RESP;
            end else if (!we || size != 2'b10) begin
              state_q <= ST_READ;
              mread_q <= 1'b1;
              maddr_q <= {2'b00, addr[31:2]};
            end else begin
              state_q  <= ST_WRITE;
              mwrite_q <= 1'b1;
              maddr_q  <= {2'b00, addr[31:2]};
              mwdata_q <= store_data;
            end
          end
        end
        ST_READ: begin
          mread_q <= 1'b0;
          ext_q   <= align_load;
          if (we_q) begin
            state_q  <= ST_WRITE;
            mwrite_q <= 1'b1;
            mwdata_q <= align_merge;
          end else begin
            state_q <= ST_RESP;
            maddr_q <= '0;
          end
        end
        ST_WRITE: begin
          state_q  <= ST_RESP;
          mwrite_q <= 1'b0;
          maddr_q  <= '0;
          mwdata_q <= '0;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          err_q   <= fault_q;
          load_q  <= (fault_q || we_q) ? '0 : ext_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready          = (state_q == ST_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign load_data      = load_q;
  assign mem_address    = maddr_q;
  assign mem_write_data = mwdata_q;
  assign mem_write      = mwrite_q;
  assign mem_read       = mread_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int unsigned MEMW = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, store_data;
  logic        ready, done, err, mem_write, mem_read;
  logic [31:0] load_data, mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:MEMW-1];

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          chk_data;
    int          lat;
    int          reads;
    int          writes;
  } exp_t;

  exp_t sbq[$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .we             (we),
    .size           (size),
    .sign_ext       (sign_ext),
    .addr           (addr),
    .store_data     (store_data),
    .ready          (ready),
    .done           (done),
    .err            (err),
    .load_data      (load_data),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  // Memory: combinational read, write on the rising edge.
  assign mem_read_data = (mem_address < MEMW) ? mem[mem_address[9:0]] : 32'h0;
  always @(posedge clk)
    if (mem_write && mem_address < MEMW) mem[mem_address[9:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the unit idle; returns at the falling
  // edge where done is seen.
  task automatic run_op(input string tag, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input logic e_err, input logic [31:0] e_data,
                        input bit e_chk, input int e_lat, input int e_rd, input int e_wr);
    exp_t e;
    int cycles, rd, wr;
    sbq.push_back('{err: e_err, data: e_data, chk_data: e_chk,
                    lat: e_lat, reads: e_rd, writes: e_wr});
    check({tag, " ready"}, 32'(ready), 32'd1);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; store_data = d;
    cycles = 0; rd = 0; wr = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!hold && cycles == 1) req = 1'b0;
      rd += int'(mem_read);
      wr += int'(mem_write);
    end while (!done && cycles < 12);
    if (!hold) req = 1'b0;
    e = sbq.pop_front();
    check({tag, " done"},   32'(done), 32'd1);
    check({tag, " err"},    32'(err), 32'(e.err));
    check({tag, " lat"},    32'(cycles - 1), 32'(e.lat));
    check({tag, " reads"},  32'(rd), 32'(e.reads));
    check({tag, " writes"}, 32'(wr), 32'(e.writes));
    if (e.chk_data) check({tag, " data"}, load_data, e.data);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; store_data = '0;
    repeat (2) @(negedge clk);
    check("rst ready",  32'(ready), 32'd1);
    check("rst done",   32'(done), 32'd0);
    check("rst err",    32'(err), 32'd0);
    check("rst mrd",    32'(mem_read), 32'd0);
    check("rst mwr",    32'(mem_write), 32'd0);
    check("rst ldata",  load_data, 32'h0);
    check("rst maddr",  mem_address, 32'h0);
    check("rst mwdata", mem_write_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // word stores: preload
    run_op("sw10", 1, 2'b10, 0, 32'h10, 32'h8899AABB, 0, 0, 0, 0, 2, 0, 1);
    run_op("sw00", 1, 2'b10, 0, 32'h00, 32'hCAFEF00D, 0, 0, 0, 0, 2, 0, 1);
    run_op("sw04", 1, 2'b10, 0, 32'h04, 32'h0BADC0DE, 0, 0, 0, 0, 2, 0, 1);
    run_op("sw08", 1, 2'b10, 0, 32'h08, 32'h11111111, 0, 0, 0, 0, 2, 0, 1);
    run_op("swFFC", 1, 2'b10, 0, 32'hFFC, 32'h5A5A5A5A, 0, 0, 0, 0, 2, 0, 1);
    check("mem4 preload", mem[4], 32'h8899AABB);

    // loads
    run_op("lb12",  0, 2'b00, 1, 32'h12, 0, 0, 0, 32'hFFFFFF99, 1, 2, 1, 0);
    run_op("lhu10", 0, 2'b01, 0, 32'h10, 0, 0, 0, 32'h0000AABB, 1, 2, 1, 0);
    run_op("lh12",  0, 2'b01, 1, 32'h12, 0, 0, 0, 32'hFFFF8899, 1, 2, 1, 0);
    run_op("lbu13", 0, 2'b00, 0, 32'h13, 0, 0, 0, 32'h00000088, 1, 2, 1, 0);
    run_op("lb10",  0, 2'b00, 1, 32'h10, 0, 0, 0, 32'hFFFFFFBB, 1, 2, 1, 0);
    run_op("lb11",  0, 2'b00, 1, 32'h11, 0, 0, 0, 32'hFFFFFFAA, 1, 2, 1, 0);
    run_op("lw10",  0, 2'b10, 0, 32'h10, 0, 0, 0, 32'h8899AABB, 1, 2, 1, 0);
    run_op("lwFFC", 0, 2'b10, 0, 32'hFFC, 0, 0, 0, 32'h5A5A5A5A, 1, 2, 1, 0);

    // sub-word stores (read-modify-write)
    run_op("sb11", 1, 2'b00, 0, 32'h11, 32'h00000055, 0, 0, 0, 0, 3, 1, 1);
    check("mem4 sb", mem[4], 32'h889955BB);
    run_op("sh12", 1, 2'b01, 0, 32'h12, 32'hABCD1234, 0, 0, 0, 0, 3, 1, 1);
    check("mem4 sh", mem[4], 32'h123455BB);
    run_op("sb13", 1, 2'b00, 0, 32'h13, 32'hFFFFFF77, 0, 0, 0, 0, 3, 1, 1);
    check("mem4 sb13", mem[4], 32'h773455BB);
    run_op("lw10b", 0, 2'b10, 0, 32'h10, 0, 0, 0, 32'h773455BB, 1, 2, 1, 0);

    // faults: no memory access, load_data cleared
    run_op("sw06",   1, 2'b10, 0, 32'h6,    32'h1, 0, 1, 32'h0, 1, 1, 0, 0);
    run_op("lw1000", 0, 2'b10, 0, 32'h1000, 0,     0, 1, 32'h0, 1, 1, 0, 0);
    run_op("lh03",   0, 2'b01, 1, 32'h3,    0,     0, 1, 32'h0, 1, 1, 0, 0);
    run_op("sz11",   0, 2'b11, 0, 32'h0,    0,     0, 1, 32'h0, 1, 1, 0, 0);
    check("mem1 after fault", mem[1], 32'h0BADC0DE);

    // back-to-back with req held; busy-cycle req must not add accesses
    run_op("b2b lw0", 0, 2'b10, 0, 32'h0, 0, 1, 0, 32'hCAFEF00D, 1, 2, 1, 0);
    run_op("b2b lw4", 0, 2'b10, 0, 32'h4, 0, 0, 0, 32'h0BADC0DE, 1, 2, 1, 0);

    // reset in the middle of a word store
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0;
    addr = 32'h8; store_data = 32'hDEADBEEF;
    @(negedge clk);
    req = 1'b0;
    check("wr state mwr", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("rst async mwr",   32'(mem_write), 32'd0);
    check("rst async maddr", mem_address, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mem2 unchanged", mem[2], 32'h11111111);
    check("ready after rst", 32'(ready), 32'd1);
    check("done after rst",  32'(done), 32'd0);
    run_op("lw08", 0, 2'b10, 0, 32'h8, 0, 0, 0, 32'h11111111, 1, 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL give the number of 32-bit words in the attached data memory; word indices at or above DEPTH are out of range.
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port req  input  1  SHALL be the pipeline access request; sampled only in IDLE.
REQ-005 Port we  input  1  SHALL select store (1) or load (0).
REQ-006 Port size  input  2  SHALL encode 00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-007 Port sign_ext  input  1  SHALL select sign (1) or zero (0) extension for sub-word loads.
REQ-008 Port addr  input  32  SHALL be the byte address.
REQ-009 Port store_data  input  32  SHALL carry store data, right-justified for sub-word stores.
REQ-010 Port ready  output  1  SHALL be high exactly when the state is IDLE.
REQ-011 Port done  output  1  SHALL pulse high for one cycle when an access completes.
REQ-012 Port err  output  1  SHALL be valid with done; high for a faulted access.
REQ-013 Port load_data  output  32  SHALL hold the extended load result, valid from done until the next accepted req.
REQ-014 Ports mem_address (output 32), mem_write_data (output 32), mem_write (output 1), mem_read (output 1), mem_read_data (input 32) SHALL connect to the word-addressed data memory.

Function
REQ-015 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-016 In IDLE with req=1, the block SHALL latch we, size, sign_ext, addr and store_data, then move to one of: RESP with err=1 on a fault; READ for a load or a sub-word store; WRITE for a word store.
REQ-017 Fault SHALL mean any of: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:2] >= DEPTH.
REQ-018 A faulted access SHALL perform no memory access and SHALL leave load_data at 0.
REQ-019 mem_address SHALL equal {2'b00, latched addr[31:2]} in READ and WRITE, and 0 otherwise.
REQ-020 mem_read SHALL be 1 only in READ, and mem_write SHALL be 1 only in WRITE; both are Moore outputs.
REQ-021 At the end of READ, the block SHALL capture mem_read_data; the memory updates its read data mid-cycle, so this is a one-cycle read.
REQ-022 After READ, the block SHALL go to RESP for a load or to WRITE for a sub-word store.
REQ-023 In WRITE for a sub-word store, mem_write_data SHALL be the captured word with only the addressed byte or halfword lane replaced; lane = addr[1:0] for bytes, addr[1] for halfwords, little-endian.
REQ-024 A load result SHALL be the addressed lane shifted to bit 0, then extended per sign_ext; a word load returns the word unchanged.
REQ-025 WRITE SHALL always go to RESP, and RESP SHALL always go to IDLE with done=1.
REQ-026 Latency from the req-accepting edge to done SHALL be:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - fault: 1 cycle
REQ-027 req SHALL be ignored while ready=0; a req held high in the cycle after done SHALL be accepted back-to-back.

Reset
REQ-028 Reset SHALL force, immediately and independent of clk:
  - state = IDLE
  - done = err = mem_read = mem_write = 0
  - load_data = mem_address = mem_write_data = 0
REQ-029 Reset asserted during WRITE SHALL drop mem_write before the next rising edge, so no partial write commits.

Structure
REQ-030 Package lsu_pkg SHALL hold the size codes, the FSM state enum and the lane-select constants.
REQ-031 The combinational extract/merge logic SHALL live in one sub-module, lsu_align, instantiated once.

Verification
REQ-032 Preload word 4 = 0x8899AABB; lb addr=0x12, sign_ext=1 -> done 2 cycles after accept, load_data=0xFFFFFF99, err=0.
REQ-033 Same preload; lhu addr=0x10 -> load_data=0x0000AABB; lh addr=0x12 -> 0xFFFF8899.
REQ-034 Preload word 4 = 0x8899AABB; sb addr=0x11, store_data=0x55 -> one READ then one WRITE of 0x889955BB, done 3 cycles after accept.
REQ-035 sw addr=0x6 -> err=1 and done 1 cycle after accept, with no mem_read or mem_write; lw addr=0x1000 with DEPTH=1024 -> err=1.
REQ-036 Assert reset during the WRITE of sw addr=0x8, data=0xDEADBEEF -> word 2 unchanged, ready=1 after reset release.
REQ-037 Hold req=1 for two back-to-back lw ops to addr 0x0 and 0x4 -> second accepted the cycle after the first done, and req during busy cycles ignored.
